// File: rtl/reorder_buffer_mc.sv
// Multi-commit reorder buffer: in-order retirement of up to COMMIT_WIDTH
// entries per cycle, CDB_PORTS write-back channels, front-end redirect on
// jalr and branch mispredict.
// Optional: define ROB_QUERY_EN to build two combinational operand-lookup
// ports for the Dispatcher (query_index / query_ready / query_data).
module reorder_buffer_mc #(
  parameter int unsigned RoB_WIDTH    = 4,
  parameter int unsigned COMMIT_WIDTH = 2,
  parameter int unsigned CDB_PORTS    = 2
) (
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  input  logic                            rdy_in,
  input  logic                            new_entry_en,
  input  logic [1:0]                      new_entry_type,
  input  logic [4:0]                      new_entry_rd,
  input  logic [31:0]                     new_entry_pc,
  input  logic [31:0]                     new_entry_alt_pc,
  input  logic                            new_entry_predict_result,
  input  logic                            already_ready,
  input  logic [31:0]                     ready_data,
  input  logic [CDB_PORTS-1:0]            CDB_update_en,
  input  logic [CDB_PORTS*RoB_WIDTH-1:0]  CDB_update_index,
  input  logic [CDB_PORTS*32-1:0]         CDB_update_data,
  output logic                            isFull,
  output logic                            isEmpty,
  output logic [RoB_WIDTH-1:0]            new_entry_index,
  output logic [COMMIT_WIDTH-1:0]         RF_update_en,
  output logic [COMMIT_WIDTH*5-1:0]       RF_update_reg,
  output logic [COMMIT_WIDTH*RoB_WIDTH-1:0] RF_update_index,
  output logic [COMMIT_WIDTH*32-1:0]      RF_update_data,
  output logic                            store_commit_en,
  output logic                            jalr_feedback_en,
  output logic [31:0]                     jalr_feedback_data,
  output logic                            branch_fail_en,
  output logic [31:0]                     correct_next_pc,
  output logic                            branch_predictor_en,
  output logic [31:0]                     branch_predictor_pc,
  output logic                            branch_predictor_result,
  output logic                            flush_signal
`ifdef ROB_QUERY_EN
  ,
  input  logic [2*RoB_WIDTH-1:0]          query_index,
  output logic [1:0]                      query_ready,
  output logic [63:0]                     query_data
`endif
);

  localparam int unsigned RoB_SIZE = 1 << RoB_WIDTH;
  localparam int unsigned CNT_W    = RoB_WIDTH + 1;

  typedef enum logic [1:0] {
    T_REGISTER = 2'd0,
    T_BRANCH   = 2'd1,
    T_JALR     = 2'd2,
    T_STORE    = 2'd3
  } entry_type_t;

  logic [RoB_WIDTH-1:0] head_ptr;
  logic [RoB_WIDTH-1:0] tail_ptr;
  logic [CNT_W-1:0]     count;

  logic [RoB_SIZE-1:0]  busy_q;
  logic [RoB_SIZE-1:0]  ready_q;
  logic [RoB_SIZE-1:0]  pred_q;
  entry_type_t          type_q   [RoB_SIZE];
  logic [4:0]           rd_q     [RoB_SIZE];
  logic [31:0]          pc_q     [RoB_SIZE];
  logic [31:0]          alt_pc_q [RoB_SIZE];
  logic [31:0]          data_q   [RoB_SIZE];

  logic                    alloc;
  logic                    chain_ok;
  logic [RoB_WIDTH-1:0]    slot_idx [COMMIT_WIDTH];
  logic [COMMIT_WIDTH-1:0] slot_retire;
  logic [CNT_W-1:0]        n_retired;

  assign isFull          = (count == CNT_W'(RoB_SIZE));
  assign isEmpty         = (count == '0);
  assign new_entry_index = tail_ptr;
  assign alloc           = new_entry_en && (count < CNT_W'(RoB_SIZE));

  // Commit selection: retire a prefix of ready entries from head, stopping
  // after the first non-REGISTER entry so side-effecting types take the last slot.
  always_comb begin
    chain_ok    = 1'b1;
    n_retired   = '0;
    slot_retire = '0;
    for (int unsigned s = 0; s < COMMIT_WIDTH; s++) begin
      slot_idx[s] = head_ptr + RoB_WIDTH'(s);
      if (chain_ok && (s < RoB_SIZE) && busy_q[slot_idx[s]] && ready_q[slot_idx[s]]) begin
        slot_retire[s] = 1'b1;
        n_retired      = n_retired + CNT_W'(1);
        if (type_q[slot_idx[s]] != T_REGISTER) chain_ok = 1'b0;
      end else begin
        chain_ok = 1'b0;
      end
    end
  end

  // State and registered outputs: reset/flush clear, rdy_in hold, else run.
  // Reset and flush share one clear path; only reset also zeroes the redirect targets.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in || (rdy_in && flush_signal)) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      busy_q   <= '0;
      ready_q  <= '0;
      pred_q   <= '0;
      for (int unsigned i = 0; i < RoB_SIZE; i++) begin
        type_q[i]   <= T_REGISTER;
        rd_q[i]     <= '0;
        pc_q[i]     <= '0;
        alt_pc_q[i] <= '0;
        data_q[i]   <= '0;
      end
      RF_update_en            <= '0;
      RF_update_reg           <= '0;
      RF_update_index         <= '0;
      RF_update_data          <= '0;
      store_commit_en         <= 1'b0;
      jalr_feedback_en        <= 1'b0;
      branch_fail_en          <= 1'b0;
      branch_predictor_en     <= 1'b0;
      branch_predictor_pc     <= '0;
      branch_predictor_result <= 1'b0;
      flush_signal            <= 1'b0;
      if (!rst_n_in) begin
        correct_next_pc    <= '0;
        jalr_feedback_data <= '0;
      end
    end else if (rdy_in) begin
      RF_update_en        <= '0;
      store_commit_en     <= 1'b0;
      jalr_feedback_en    <= 1'b0;
      branch_fail_en      <= 1'b0;
      branch_predictor_en <= 1'b0;
      flush_signal        <= 1'b0;

      // Write-back: ascending channel order lets the highest channel win.
      for (int unsigned k = 0; k < CDB_PORTS; k++) begin
        if (CDB_update_en[k] && busy_q[CDB_update_index[k*RoB_WIDTH +: RoB_WIDTH]]) begin
          ready_q[CDB_update_index[k*RoB_WIDTH +: RoB_WIDTH]] <= 1'b1;
          data_q[CDB_update_index[k*RoB_WIDTH +: RoB_WIDTH]]  <= CDB_update_data[k*32 +: 32];
        end
      end

      for (int unsigned s = 0; s < COMMIT_WIDTH; s++) begin
        if (slot_retire[s]) begin
          busy_q[slot_idx[s]]   <= 1'b0;
          ready_q[slot_idx[s]]  <= 1'b0;
          pred_q[slot_idx[s]]   <= 1'b0;
          type_q[slot_idx[s]]   <= T_REGISTER;
          rd_q[slot_idx[s]]     <= '0;
          pc_q[slot_idx[s]]     <= '0;
          alt_pc_q[slot_idx[s]] <= '0;
          data_q[slot_idx[s]]   <= '0;
          case (type_q[slot_idx[s]])
            T_REGISTER: begin
              RF_update_en[s]                            <= 1'b1;
              RF_update_reg[s*5 +: 5]                    <= rd_q[slot_idx[s]];
              RF_update_index[s*RoB_WIDTH +: RoB_WIDTH]  <= slot_idx[s];
              RF_update_data[s*32 +: 32]                 <= data_q[slot_idx[s]];
            end
            T_BRANCH: begin
              branch_predictor_en     <= 1'b1;
              branch_predictor_pc     <= pc_q[slot_idx[s]];
              branch_predictor_result <= data_q[slot_idx[s]][0];
              if (data_q[slot_idx[s]][0] != pred_q[slot_idx[s]]) begin
                branch_fail_en  <= 1'b1;
                correct_next_pc <= alt_pc_q[slot_idx[s]];
                flush_signal    <= 1'b1;
              end
            end
            T_JALR: begin
              RF_update_en[s]                            <= 1'b1;
              RF_update_reg[s*5 +: 5]                    <= rd_q[slot_idx[s]];
              RF_update_index[s*RoB_WIDTH +: RoB_WIDTH]  <= slot_idx[s];
              RF_update_data[s*32 +: 32]                 <= pc_q[slot_idx[s]] + 32'd4;
              jalr_feedback_en                           <= 1'b1;
              jalr_feedback_data                         <= data_q[slot_idx[s]];
            end
            default: begin
              store_commit_en <= 1'b1;
            end
          endcase
        end
      end

      // The tail slot is never busy when alloc is set, so it cannot collide
      // with a retiring slot or an accepted CDB write.
      if (alloc) begin
        busy_q[tail_ptr]   <= 1'b1;
        ready_q[tail_ptr]  <= already_ready;
        pred_q[tail_ptr]   <= new_entry_predict_result;
        type_q[tail_ptr]   <= entry_type_t'(new_entry_type);
        rd_q[tail_ptr]     <= new_entry_rd;
        pc_q[tail_ptr]     <= new_entry_pc;
        alt_pc_q[tail_ptr] <= new_entry_alt_pc;
        data_q[tail_ptr]   <= already_ready ? ready_data : '0;
        tail_ptr           <= tail_ptr + RoB_WIDTH'(1);
      end

      head_ptr <= head_ptr + n_retired[RoB_WIDTH-1:0];
      count    <= count + CNT_W'(alloc) - n_retired;
    end
  end

`ifdef ROB_QUERY_EN
  logic [RoB_WIDTH-1:0] q_idx [2];

  // Operand lookup with same-cycle CDB bypass for busy entries.
  always_comb begin
    query_ready = '0;
    query_data  = '0;
    for (int unsigned p = 0; p < 2; p++) begin
      q_idx[p] = query_index[p*RoB_WIDTH +: RoB_WIDTH];
      if (busy_q[q_idx[p]]) begin
        query_ready[p]         = ready_q[q_idx[p]];
        query_data[p*32 +: 32] = data_q[q_idx[p]];
        for (int unsigned k = 0; k < CDB_PORTS; k++) begin
          if (CDB_update_en[k] && (CDB_update_index[k*RoB_WIDTH +: RoB_WIDTH] == q_idx[p])) begin
            query_ready[p]         = 1'b1;
            query_data[p*32 +: 32] = CDB_update_data[k*32 +: 32];
          end
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_reorder_buffer_mc.sv
// Directed bench for reorder_buffer_mc with default geometry (16 entries,
// 2 commit slots, 2 CDB channels). Query checks build only with ROB_QUERY_EN.
module tb_reorder_buffer_mc;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = 2;
  localparam int unsigned CP = 2;

  logic              clk_in = 1'b0;
  logic              rst_n_in = 1'b0;
  logic              rdy_in = 1'b1;
  logic              new_entry_en = 1'b0;
  logic [1:0]        new_entry_type = '0;
  logic [4:0]        new_entry_rd = '0;
  logic [31:0]       new_entry_pc = '0;
  logic [31:0]       new_entry_alt_pc = '0;
  logic              new_entry_predict_result = 1'b0;
  logic              already_ready = 1'b0;
  logic [31:0]       ready_data = '0;
  logic [CP-1:0]     CDB_update_en = '0;
  logic [CP*W-1:0]   CDB_update_index = '0;
  logic [CP*32-1:0]  CDB_update_data = '0;
  logic              isFull, isEmpty;
  logic [W-1:0]      new_entry_index;
  logic [CW-1:0]     RF_update_en;
  logic [CW*5-1:0]   RF_update_reg;
  logic [CW*W-1:0]   RF_update_index;
  logic [CW*32-1:0]  RF_update_data;
  logic              store_commit_en, jalr_feedback_en, branch_fail_en;
  logic [31:0]       jalr_feedback_data, correct_next_pc, branch_predictor_pc;
  logic              branch_predictor_en, branch_predictor_result, flush_signal;
`ifdef ROB_QUERY_EN
  logic [2*W-1:0]    query_index = '0;
  logic [1:0]        query_ready;
  logic [63:0]       query_data;
`endif

  int checks = 0;
  int errors = 0;

  reorder_buffer_mc #(.RoB_WIDTH(W), .COMMIT_WIDTH(CW), .CDB_PORTS(CP)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .new_entry_en(new_entry_en), .new_entry_type(new_entry_type),
    .new_entry_rd(new_entry_rd), .new_entry_pc(new_entry_pc),
    .new_entry_alt_pc(new_entry_alt_pc),
    .new_entry_predict_result(new_entry_predict_result),
    .already_ready(already_ready), .ready_data(ready_data),
    .CDB_update_en(CDB_update_en), .CDB_update_index(CDB_update_index),
    .CDB_update_data(CDB_update_data),
    .isFull(isFull), .isEmpty(isEmpty), .new_entry_index(new_entry_index),
    .RF_update_en(RF_update_en), .RF_update_reg(RF_update_reg),
    .RF_update_index(RF_update_index), .RF_update_data(RF_update_data),
    .store_commit_en(store_commit_en),
    .jalr_feedback_en(jalr_feedback_en), .jalr_feedback_data(jalr_feedback_data),
    .branch_fail_en(branch_fail_en), .correct_next_pc(correct_next_pc),
    .branch_predictor_en(branch_predictor_en),
    .branch_predictor_pc(branch_predictor_pc),
    .branch_predictor_result(branch_predictor_result),
    .flush_signal(flush_signal)
`ifdef ROB_QUERY_EN
    , .query_index(query_index), .query_ready(query_ready), .query_data(query_data)
`endif
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_alloc(input logic en, input logic [1:0] t, input logic [4:0] rd,
                           input logic [31:0] pc, input logic [31:0] alt, input logic pred,
                           input logic rdy, input logic [31:0] d);
    new_entry_en = en; new_entry_type = t; new_entry_rd = rd;
    new_entry_pc = pc; new_entry_alt_pc = alt; new_entry_predict_result = pred;
    already_ready = rdy; ready_data = d;
  endtask

  task automatic cdb(input logic [1:0] en, input logic [3:0] i1, input logic [3:0] i0,
                     input logic [31:0] d1, input logic [31:0] d0);
    CDB_update_en = en;
    CDB_update_index = {i1, i0};
    CDB_update_data = {d1, d0};
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_isEmpty", 32'(isEmpty), 32'd1);
    chk("rst_isFull", 32'(isFull), 32'd0);
    chk("rst_index", 32'(new_entry_index), 32'd0);
    chk("rst_rf_en", 32'(RF_update_en), 32'd0);
    chk("rst_flush", 32'(flush_signal), 32'd0);
    chk("rst_next_pc", correct_next_pc, 32'd0);
    rst_n_in = 1'b1;

    // Fill all 16 entries with not-ready REGISTER instructions
    for (int i = 0; i < 15; i++) begin
      set_alloc(1'b1, 2'd0, 5'(i + 1), 32'h1000 + 32'(i * 4), '0, 1'b0, 1'b0, '0);
      tick();
    end
    chk("fill15_full", 32'(isFull), 32'd0);
    chk("fill15_index", 32'(new_entry_index), 32'd15);
    set_alloc(1'b1, 2'd0, 5'd16, 32'h103C, '0, 1'b0, 1'b0, '0);
    tick();
    chk("fill16_full", 32'(isFull), 32'd1);
    chk("fill16_index", 32'(new_entry_index), 32'd0);
    set_alloc(1'b1, 2'd0, 5'd17, 32'h1040, '0, 1'b0, 1'b0, '0);
    tick();
    chk("over_full", 32'(isFull), 32'd1);
    chk("over_index", 32'(new_entry_index), 32'd0);
    set_alloc(1'b0, 2'd0, '0, '0, '0, 1'b0, 1'b0, '0);

    // Two channels complete entries 0 and 1; both commit the following cycle
    cdb(2'b11, 4'd1, 4'd0, 32'hB, 32'hA);
    tick();
    chk("cdb_no_early_commit", 32'(RF_update_en), 32'd0);
    cdb(2'b00, 4'd0, 4'd0, '0, '0);
    tick();
    chk("dual_rf_en", 32'(RF_update_en), 32'd3);
    chk("dual_rd0", 32'(RF_update_reg[4:0]), 32'd1);
    chk("dual_rd1", 32'(RF_update_reg[9:5]), 32'd2);
    chk("dual_data0", RF_update_data[31:0], 32'hA);
    chk("dual_data1", RF_update_data[63:32], 32'hB);
    chk("dual_idx0", 32'(RF_update_index[3:0]), 32'd0);
    chk("dual_idx1", 32'(RF_update_index[7:4]), 32'd1);
    chk("dual_not_full", 32'(isFull), 32'd0);

    // Same-index collision: highest channel wins on entry 3
    cdb(2'b11, 4'd3, 4'd3, 32'h22, 32'h11);
    tick();
    cdb(2'b01, 4'd0, 4'd2, '0, 32'h2C);
    tick();
    chk("blocked_head", 32'(RF_update_en), 32'd0);
    cdb(2'b00, 4'd0, 4'd0, '0, '0);
    tick();
    chk("coll_rf_en", 32'(RF_update_en), 32'd3);
    chk("coll_idx0", 32'(RF_update_index[3:0]), 32'd2);
    chk("coll_data0", RF_update_data[31:0], 32'h2C);
    chk("coll_idx1", 32'(RF_update_index[7:4]), 32'd3);
    chk("coll_data1", RF_update_data[63:32], 32'h22);

    // Mid-stream reset clears outputs and pointers
    rst_n_in = 1'b0;
    tick();
    chk("midrst_rf_en", 32'(RF_update_en), 32'd0);
    chk("midrst_rf_data", RF_update_data[63:32], 32'd0);
    chk("midrst_empty", 32'(isEmpty), 32'd1);
    chk("midrst_index", 32'(new_entry_index), 32'd0);
    rst_n_in = 1'b1;

    // Mispredicted branch at head, ready REGISTER behind it
    set_alloc(1'b1, 2'd1, 5'd0, 32'h200, 32'h100, 1'b1, 1'b0, '0);
    tick();
    set_alloc(1'b1, 2'd0, 5'd5, 32'h204, '0, 1'b0, 1'b1, 32'h55);
    tick();
    set_alloc(1'b0, 2'd0, '0, '0, '0, 1'b0, 1'b0, '0);
    cdb(2'b01, 4'd0, 4'd0, '0, 32'h0);
    tick();
    chk("br_not_yet", 32'(branch_fail_en), 32'd0);
    cdb(2'b00, 4'd0, 4'd0, '0, '0);
    tick();
    chk("br_fail_en", 32'(branch_fail_en), 32'd1);
    chk("br_next_pc", correct_next_pc, 32'h100);
    chk("br_flush", 32'(flush_signal), 32'd1);
    chk("br_bp_en", 32'(branch_predictor_en), 32'd1);
    chk("br_bp_pc", branch_predictor_pc, 32'h200);
    chk("br_bp_result", 32'(branch_predictor_result), 32'd0);
    chk("br_only_branch", 32'(RF_update_en), 32'd0);
    chk("br_count1", 32'(isEmpty), 32'd0);
    chk("br_tail", 32'(new_entry_index), 32'd2);
    set_alloc(1'b1, 2'd0, 5'd9, 32'h600, '0, 1'b0, 1'b1, 32'h99);
    cdb(2'b01, 4'd0, 4'd1, '0, 32'h77);
    tick();
    chk("flush_empty", 32'(isEmpty), 32'd1);
    chk("flush_index", 32'(new_entry_index), 32'd0);
    chk("flush_drop", 32'(flush_signal), 32'd0);
    chk("flush_fail_drop", 32'(branch_fail_en), 32'd0);
    chk("flush_pc_hold", correct_next_pc, 32'h100);
    chk("flush_rf_en", 32'(RF_update_en), 32'd0);
    set_alloc(1'b0, 2'd0, '0, '0, '0, 1'b0, 1'b0, '0);
    cdb(2'b00, 4'd0, 4'd0, '0, '0);
    tick();
    chk("post_flush_empty", 32'(isEmpty), 32'd1);
    chk("post_flush_rf", 32'(RF_update_en), 32'd0);

    // STORE in slot 0 ahead of a ready REGISTER
    set_alloc(1'b1, 2'd3, 5'd0, 32'h300, '0, 1'b0, 1'b1, '0);
    tick();
    set_alloc(1'b1, 2'd0, 5'd7, 32'h304, '0, 1'b0, 1'b1, 32'h77);
    tick();
    chk("st_commit", 32'(store_commit_en), 32'd1);
    chk("st_no_rf", 32'(RF_update_en), 32'd0);
    set_alloc(1'b0, 2'd0, '0, '0, '0, 1'b0, 1'b0, '0);
    tick();
    chk("st_pulse_drop", 32'(store_commit_en), 32'd0);
    chk("st_reg_rf_en", 32'(RF_update_en), 32'd1);
    chk("st_reg_rd", 32'(RF_update_reg[4:0]), 32'd7);
    chk("st_reg_data", RF_update_data[31:0], 32'h77);
    chk("st_reg_idx", 32'(RF_update_index[3:0]), 32'd1);
    chk("st_empty", 32'(isEmpty), 32'd1);

    // JALR writes pc+4 and returns its target
    set_alloc(1'b1, 2'd2, 5'd1, 32'h500, '0, 1'b0, 1'b1, 32'h400);
    tick();
    set_alloc(1'b0, 2'd0, '0, '0, '0, 1'b0, 1'b0, '0);
    tick();
    chk("jalr_rf_en", 32'(RF_update_en), 32'd1);
    chk("jalr_rf_data", RF_update_data[31:0], 32'h504);
    chk("jalr_rf_idx", 32'(RF_update_index[3:0]), 32'd2);
    chk("jalr_fb_en", 32'(jalr_feedback_en), 32'd1);
    chk("jalr_fb_data", jalr_feedback_data, 32'h400);
    chk("jalr_no_flush", 32'(flush_signal), 32'd0);

    // rdy_in low freezes everything
    rdy_in = 1'b0;
    set_alloc(1'b1, 2'd0, 5'd3, 32'h700, '0, 1'b0, 1'b1, 32'h3);
    tick();
    chk("hold_rf_en", 32'(RF_update_en), 32'd1);
    chk("hold_fb_en", 32'(jalr_feedback_en), 32'd1);
    chk("hold_index", 32'(new_entry_index), 32'd3);
    rdy_in = 1'b1;
    set_alloc(1'b0, 2'd0, '0, '0, '0, 1'b0, 1'b0, '0);
    tick();
    chk("unhold_fb_en", 32'(jalr_feedback_en), 32'd0);
    chk("unhold_rf_en", 32'(RF_update_en), 32'd0);

    // Pointer wrap: walk head to 14, then commit 14/15 then 0
    rst_n_in = 1'b0;
    tick();
    rst_n_in = 1'b1;
    for (int i = 0; i < 14; i++) begin
      set_alloc(1'b1, 2'd0, 5'd1, 32'h800 + 32'(i * 4), '0, 1'b0, 1'b1, 32'(i));
      tick();
    end
    set_alloc(1'b0, 2'd0, '0, '0, '0, 1'b0, 1'b0, '0);
    tick();
    chk("walk_empty", 32'(isEmpty), 32'd1);
    chk("walk_index", 32'(new_entry_index), 32'd14);
    for (int i = 0; i < 3; i++) begin
      set_alloc(1'b1, 2'd0, 5'(20 + i), 32'h900 + 32'(i * 4), '0, 1'b0, 1'b0, '0);
      tick();
    end
    set_alloc(1'b0, 2'd0, '0, '0, '0, 1'b0, 1'b0, '0);
    chk("wrap_tail", 32'(new_entry_index), 32'd1);
    cdb(2'b11, 4'd15, 4'd14, 32'hF0, 32'hE0);
    tick();
    cdb(2'b01, 4'd0, 4'd0, '0, 32'h0D);
    tick();
    chk("wrap_rf_en_a", 32'(RF_update_en), 32'd3);
    chk("wrap_idx0_a", 32'(RF_update_index[3:0]), 32'd14);
    chk("wrap_idx1_a", 32'(RF_update_index[7:4]), 32'd15);
    chk("wrap_data0_a", RF_update_data[31:0], 32'hE0);
    chk("wrap_data1_a", RF_update_data[63:32], 32'hF0);
    chk("wrap_rd1_a", 32'(RF_update_reg[9:5]), 32'd21);
    cdb(2'b00, 4'd0, 4'd0, '0, '0);
    tick();
    chk("wrap_rf_en_b", 32'(RF_update_en), 32'd1);
    chk("wrap_idx0_b", 32'(RF_update_index[3:0]), 32'd0);
    chk("wrap_rd0_b", 32'(RF_update_reg[4:0]), 32'd22);
    chk("wrap_data0_b", RF_update_data[31:0], 32'h0D);
    chk("wrap_empty", 32'(isEmpty), 32'd1);

`ifdef ROB_QUERY_EN
    // Entries 1..5 busy, not ready; query 5 sees the CDB bypass, 2 sees stored state
    for (int i = 0; i < 5; i++) begin
      set_alloc(1'b1, 2'd0, 5'(i + 1), 32'hA00 + 32'(i * 4), '0, 1'b0, 1'b0, '0);
      tick();
    end
    set_alloc(1'b0, 2'd0, '0, '0, '0, 1'b0, 1'b0, '0);
    query_index = {4'd2, 4'd5};
    cdb(2'b01, 4'd0, 4'd5, '0, 32'h55);
    #1;
    chk("q_ready", 32'(query_ready), 32'd1);
    chk("q_data0", query_data[31:0], 32'h55);
    chk("q_data1", query_data[63:32], 32'h0);
    tick();
    cdb(2'b00, 4'd0, 4'd0, '0, '0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reorder_buffer_mc.md
Name: reorder_buffer_mc

Overview:
- Parametrised multi-commit reorder buffer for the out-of-order core; successor of the single-commit RoB.
- Sits between Dispatcher (allocation), CDB (CDB_PORTS result channels), Register File, IF and branch predictor.
- Retires up to COMMIT_WIDTH entries in order per cycle and redirects the front end on jalr or branch mispredict.
- Optional operand-lookup read ports for the Dispatcher.

Parameters:
RoB_WIDTH, 4, log2 of entry count; RoB_SIZE = 1 << RoB_WIDTH.
COMMIT_WIDTH, 2, maximum retirements per cycle (1..4).
CDB_PORTS, 2, number of independent CDB write-back channels (1..4).

Ports:
clk_in  in  1  clock; all state changes on posedge.
rst_n_in  in  1  synchronous reset, active-low.
rdy_in  in  1  global enable; low freezes all state and holds all outputs.
new_entry_en  in  1  allocation request.
new_entry_type  in  2  0 REGISTER, 1 BRANCH, 2 JALR, 3 STORE.
new_entry_rd  in  5  destination register; 0 = no write.
new_entry_pc  in  32  instruction pc.
new_entry_alt_pc  in  32  pc of the non-predicted path (branches only).
new_entry_predict_result  in  1  predicted taken.
already_ready  in  1  entry result known at dispatch.
ready_data  in  32  result when already_ready.
CDB_update_en  in  CDB_PORTS  per-channel valid.
CDB_update_index  in  CDB_PORTS*RoB_WIDTH  packed entry indices; channel k at [k*RoB_WIDTH +: RoB_WIDTH].
CDB_update_data  in  CDB_PORTS*32  packed results.
isFull  out  1  count == RoB_SIZE.
isEmpty  out  1  count == 0.
new_entry_index  out  RoB_WIDTH  tail_ptr.
RF_update_en  out  COMMIT_WIDTH  per-slot write pulse.
RF_update_reg  out  COMMIT_WIDTH*5  packed rd.
RF_update_index  out  COMMIT_WIDTH*RoB_WIDTH  packed committing index.
RF_update_data  out  COMMIT_WIDTH*32  packed value.
store_commit_en  out  1  pulse: head store retired; LSB may write memory.
jalr_feedback_en  out  1  jalr target pulse.
jalr_feedback_data  out  32  jalr target.
branch_fail_en  out  1  mispredict redirect pulse.
correct_next_pc  out  32  redirect pc.
branch_predictor_en  out  1  branch-retire pulse.
branch_predictor_pc  out  32  retired branch pc.
branch_predictor_result  out  1  actual taken.
flush_signal  out  1  one-cycle global flush.
query_index  in  2*RoB_WIDTH  (ROB_QUERY_EN only) two lookup indices.
query_ready  out  2  (ROB_QUERY_EN only) per-port ready.
query_data  out  64  (ROB_QUERY_EN only) per-port data.

Behaviour:
- Reset (rst_n_in low at posedge):
  - head_ptr, tail_ptr and count = 0; all entry fields cleared.
  - Every registered output = 0.
  - Reset has priority over rdy_in and flush.
- Priority: reset > !rdy_in (hold) > flush_signal > run.
- flush_signal high at a posedge:
  - Identical clear to reset, except correct_next_pc and jalr_feedback_data hold their values.
  - All pulses drop to 0.
  - Allocation and CDB inputs are ignored that cycle.
- Run: all output pulses default to 0 each cycle.
- Allocate:
  - Occurs when new_entry_en and count < RoB_SIZE, evaluated on pre-edge count; no same-cycle reuse of freed slots.
  - Writes the entry at tail_ptr; tail_ptr wraps modulo RoB_SIZE.
  - isReady = already_ready; data = already_ready ? ready_data : 0.
- CDB write-back:
  - Channel k with valid set writes data and sets ready only if the entry is busy (pre-edge).
  - Writes to non-busy indices are dropped.
  - If several channels hit the same index, the highest k wins.
  - CDB writes are visible to commit from the next cycle.
- Commit:
  - Slot s examines entry head+s (mod RoB_SIZE).
  - Slot s retires iff the entry is busy and ready, slots 0..s-1 all retired, and all of them were REGISTER.
  - Consequence: at most one BRANCH/JALR/STORE per cycle, and always in the last retiring slot.
  - Retired entries are cleared; head_ptr advances by the number retired.
  - count_next = count + alloc - retired.
- Per-type actions, registered (visible the cycle after the commit edge):
  - REGISTER: RF_update_en[s]=1 with rd, index and data (the rd=0 filter is the RF's job).
  - BRANCH: branch_predictor_en=1 with pc and data[0].
    - If data[0] != predict_result: branch_fail_en=1, correct_next_pc=alt_pc, flush_signal=1.
    - flush_signal rises together with branch_fail_en.
  - JALR: RF write in slot s with pc+4; jalr_feedback_en=1 with data. No flush.
  - STORE: store_commit_en=1; no RF write.
- isFull and isEmpty are combinational from count. Full+empty ambiguity is impossible because count is explicit.
- Pointer arithmetic is modulo 2^RoB_WIDTH via natural wrap.

Optional Feature:
- Macro ROB_QUERY_EN.
- Defined:
  - query_ready and query_data are combinational per port.
  - If any CDB channel currently targets query_index (busy entry): ready=1, data = winning channel data (same priority rule).
  - Otherwise returns the stored isReady and data; non-busy index returns 0/0.
- Undefined: the query ports are absent and no query logic is built.

Test Plan:
- Reset then allocate 16 REGISTER entries (rd=1..16, already_ready=0) -> isFull=1 after 16th; 17th request ignored; new_entry_index=0.
- CDB channels 0 and 1 in one cycle write indices 0 and 1 (0xA, 0xB) -> next cycle RF_update_en=2'b11 with rd 1,2 and data 0xA,0xB; head=2.
- Both channels target index 3 with 0x11 and 0x22 -> entry 3 commits 0x22.
- Head BRANCH (predict 1, CDB data 0, alt_pc 0x100) followed by a ready REGISTER -> only the branch retires. branch_fail_en=1, correct_next_pc=0x100, flush_signal=1, branch_predictor_result=0. Next cycle isEmpty=1 and new requests in the flush cycle are dropped.
- Slot 0 STORE ready and slot 1 REGISTER ready -> cycle 1: store_commit_en only; cycle 2: RF_update_en[0]=1 for the register.
- Wrap: head=14, entries at 14,15,0 ready -> commits at 14/15, then 0; head=1. Also: rst_n_in low mid-stream -> all outputs 0 next cycle. With ROB_QUERY_EN, query of index 5 during a CDB write of 0x55 -> ready=1, data=0x55 in the same cycle.
